// File: rtl/reqack2rdyval_fifo.sv
// Purpose : request/acknowledge (two- or four-phase) to ready/valid bridge with a DEPTH-entry FIFO.
// Latency : req edge -> ack and req edge -> vld are SYNC_STAGES+1 clk; pushed data is on o_dat one clk later.
// Backpr. : when full, the pending request is held unacknowledged and no data is lost.
// Ports   : clk/rst_n (async, active-low); req/ack/i_dat sender side; vld/rdy/o_dat consumer side;
//           level = FIFO occupancy 0..DEPTH.
module reqack2rdyval_fifo #(
  parameter int DWIDTH      = 8,
  parameter int DEPTH       = 2,
  parameter int SYNC_STAGES = 0,
  parameter int FOUR_PHASE  = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req,
  output logic                         ack,
  input  logic [DWIDTH-1:0]            i_dat,
  output logic                         vld,
  input  logic                         rdy,
  output logic [DWIDTH-1:0]            o_dat,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  typedef enum logic {ST_IDLE, ST_ACKED} state_e;

  logic              req_s;
  logic              full;
  logic              push;
  logic              pop;
  state_e            state_q, state_d;
  logic              ack_q, ack_d;
  logic              req_prev_q, req_prev_d;
  logic [LW-1:0]     level_q, level_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [DWIDTH-1:0] mem_q [DEPTH];

  // Request synchroniser; i_dat is deliberately not synchronised because the
  // sender holds it stable until it sees the matching ack.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign req_s = req;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= req;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end
      assign req_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // full comes from the registered level only, so a same-cycle pop never
  // unblocks a push: no combinational rdy -> ack path.
  assign full = (level_q == FULL_LVL);
  assign vld  = (level_q != '0);
  assign pop  = vld & rdy;

  // Sender-side handshake. Two-phase: any difference between the synchronised
  // req and the last accepted level is a pending request. Four-phase: one push
  // per high phase, ack released once req returns to zero.
  always_comb begin
    state_d    = state_q;
    ack_d      = ack_q;
    req_prev_d = req_prev_q;
    push       = 1'b0;
    if (FOUR_PHASE != 0) begin
      case (state_q)
        ST_IDLE: begin
          if (req_s && !full) begin
            push    = 1'b1;
            ack_d   = 1'b1;
            state_d = ST_ACKED;
          end
        end
        ST_ACKED: begin
          if (!req_s) begin
            ack_d   = 1'b0;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if ((req_s != req_prev_q) && !full) begin
      push       = 1'b1;
      req_prev_d = req_s;
      ack_d      = ~ack_q;
    end
  end

  // Occupancy and pointers; pointers wrap explicitly so any DEPTH works.
  always_comb begin
    level_d  = level_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (push) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ack_q      <= 1'b0;
      req_prev_q <= 1'b0;
      level_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      req_prev_q <= req_prev_d;
      level_q    <= level_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage is not reset; o_dat is only meaningful while vld is high.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_dat;
    end
  end

  assign o_dat = mem_q[rd_ptr_q];
  assign ack   = ack_q;
  assign level = level_q;

endmodule

// File: doc/reqack2rdyval_fifo.md
Name: reqack2rdyval_fifo

Overview:
Converts an input Request–Acknowledge handshake (two-phase or four-phase, selected at elaboration) into an output Ready–Valid stream. A DEPTH-entry FIFO sits between the two sides, so the sender can keep handshaking while the consumer stalls. An optional N-stage synchroniser on req allows the block to sit on the receiving side of a clock domain crossing.

Parameters:
DWIDTH, 8, data path bit width (>=1)
DEPTH, 2, FIFO entries (>=1)
SYNC_STAGES, 0, req synchroniser flops; 0 = none (same clock domain), otherwise >=2
FOUR_PHASE, 0, 0 = two-phase (toggle) protocol; 1 = four-phase (level, return-to-zero) protocol

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous reset, active-low
req  input  1  request from sender; may be asynchronous when SYNC_STAGES>0
ack  output  1  acknowledge to sender, driven directly from a flop
i_dat  input  DWIDTH  request data; stable from req assertion/toggle until the matching ack response
vld  output  1  output data valid
rdy  input  1  consumer ready
o_dat  output  DWIDTH  head-of-FIFO data
level  output  $clog2(DEPTH+1)  FIFO occupancy, 0..DEPTH

Behaviour:
- Reset (async, rst_n=0): ack=0, vld=0, level=0, synchroniser flops=0, req_d=0, FSM=IDLE, pointers=0. FIFO storage is not reset; o_dat is don't-care while vld=0.
- req_i: req after SYNC_STAGES flops, or req directly when SYNC_STAGES=0. i_dat is never synchronised; the sender's protocol guarantees it is stable.
- full = (level==DEPTH); empty = (level==0).
- Two-phase (FOUR_PHASE=0):
  - event = req_i ^ req_d.
  - push = event & ~full.
  - On push: write i_dat, set req_d<=req_i, toggle ack.
  - While full, the event stays pending, with no ack change and no data loss.
- Four-phase (FOUR_PHASE=1), FSM with states IDLE and ACKED:
  - IDLE: if req_i=1 and ~full, then push, ack<=1, go to ACKED. If full, stay in IDLE and hold.
  - ACKED: when req_i=0, ack<=0 and go to IDLE. No push happens in ACKED.
  - One push per req high phase.
- Output side:
  - vld = ~empty, registered or derived from the level register, with no combinational path from req.
  - o_dat = mem[rd_ptr].
  - pop = vld & rdy.
  - rd_ptr and wr_ptr wrap from DEPTH-1 to 0; non-power-of-two DEPTH must be supported.
- Push and pop in the same cycle:
  - If not full, both happen and level is unchanged.
  - If full, push is blocked this cycle (full is evaluated from the registered level); the pop proceeds and the push lands on the next cycle.
  - No combinational rdy→ack path.
- Latency:
  - req edge to ack response = SYNC_STAGES+1 clk when not full.
  - req edge to vld (empty FIFO) = SYNC_STAGES+1 clk.
  - Data pushed at cycle t is visible on o_dat at t+1.
- Throughput:
  - Two-phase with SYNC_STAGES=0 sustains one push per round trip of the sender.
  - The output sustains one pop per cycle.
- Ordering: strict FIFO order; no drop, no duplication.
- Reset mid-operation clears all state immediately. Pending entries are lost and ack returns to 0; the sender must also be reset so its phase reference realigns.
- Assertions (bench):
  - level never exceeds DEPTH and never underflows.
  - ack changes only on a push (two-phase) or an FSM transition (four-phase).
  - o_dat stable while vld & ~rdy.

Test Plan:
1. Two-phase, SYNC_STAGES=0, DEPTH=2, rdy=1. Toggle req with i_dat=0xA5 → ack toggles at +1 clk, vld=1 with o_dat=0xA5 at +1 clk, vld=0 the cycle after.
2. Two-phase, rdy=0. Send 3 toggles with data 0x01, 0x02, 0x03 → first two acked and level=2, third toggle not acked. Raise rdy → pops return 0x01, 0x02, 0x03 in order, third ack toggles one cycle after the first pop.
3. Four-phase, DEPTH=1, rdy=1. Raise req with 0x3C → ack=1, push once; hold req high 5 cycles → exactly one entry. Drop req → ack=0 at +1 clk.
4. SYNC_STAGES=2, two-phase, empty FIFO. req toggle → ack and vld both rise at +3 clk. Verify with req toggled asynchronously to clk.
5. DEPTH=3 (non-power-of-two), rdy=1. Stream 10 words 0..9 → pointers wrap cleanly, output sequence 0..9 intact, level never above 3.
6. Reset with level=2 and four-phase FSM in ACKED → vld=0, ack=0, level=0 immediately. After release, a fresh req handshake works normally.
